// File: rtl/divider_sched_pkg.sv
// Shared types and constants for the round-robin divider scheduler.
// Response fields are sized for up to 32-bit operands and 8 requesters.
package divider_sched_pkg;

  localparam int RSP_MAX_W = 32;
  localparam int RSP_ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } sched_state_t;

  localparam logic [RSP_MAX_W-1:0] DIV0_QUOTIENT = '1;

  typedef struct packed {
    logic [RSP_ID_W-1:0]  id;
    logic [RSP_MAX_W-1:0] quotient;
    logic [RSP_MAX_W-1:0] remainder;
    logic                 div_by_zero;
    logic                 timeout;
  } sched_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping around, as a one-hot vector plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int IDW = $clog2(NUM_REQ);

  // Offset i is scanned in order, so the first hit is the nearest one after ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!any && req[k] && (k == (int'(ptr) + i) % NUM_REQ)) begin
          any       = 1'b1;
          grant[k]  = 1'b1;
          grant_idx = IDW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/divider_sched_rr.sv
// Shares one start/done divider among NUM_REQ requesters with round-robin
// arbitration, divide-by-zero bypass and a WAIT-state watchdog.
module divider_sched_rr
  import divider_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic [WIDTH-1:0]           rsp_remainder,
  output logic                       rsp_div_by_zero,
  output logic                       rsp_timeout,
  output logic                       div_start,
  output logic [WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder,
  input  logic                       div_done,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  sched_state_t     state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  sched_rsp_t       rsp_q, rsp_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               any_req;
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;
  logic [IDW-1:0]     next_ptr;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (any_req)
  );

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_dividend = req_dividend[k*WIDTH +: WIDTH];
        sel_divisor  = req_divisor[k*WIDTH +: WIDTH];
      end
    end
    next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

  // A zero divisor is answered straight from IDLE and never reaches the divider.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    rsp_d      = rsp_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          ptr_d      = next_ptr;
          id_d       = grant_idx;
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          cnt_d      = '0;
          if (sel_divisor == '0) begin
            rsp_d.id          = RSP_ID_W'(grant_idx);
            rsp_d.quotient    = DIV0_QUOTIENT;
            rsp_d.remainder   = RSP_MAX_W'(sel_dividend);
            rsp_d.div_by_zero = 1'b1;
            rsp_d.timeout     = 1'b0;
            state_d           = RESPOND;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          rsp_d.id          = RSP_ID_W'(id_q);
          rsp_d.quotient    = RSP_MAX_W'(div_quotient);
          rsp_d.remainder   = RSP_MAX_W'(div_remainder);
          rsp_d.div_by_zero = 1'b0;
          rsp_d.timeout     = 1'b0;
          state_d           = RESPOND;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_d.id          = RSP_ID_W'(id_q);
          rsp_d.quotient    = '0;
          rsp_d.remainder   = '0;
          rsp_d.div_by_zero = 1'b0;
          rsp_d.timeout     = 1'b1;
          state_d           = RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      rsp_q      <= rsp_d;
    end
  end

  assign req_ready       = (state_q == IDLE && !rst) ? grant : '0;
  assign div_start       = (state_q == ISSUE);
  assign div_dividend    = dividend_q;
  assign div_divisor     = divisor_q;
  assign rsp_valid       = (state_q == RESPOND);
  assign rsp_id          = rsp_q.id[IDW-1:0];
  assign rsp_quotient    = rsp_q.quotient[WIDTH-1:0];
  assign rsp_remainder   = rsp_q.remainder[WIDTH-1:0];
  assign rsp_div_by_zero = rsp_q.div_by_zero;
  assign rsp_timeout     = rsp_q.timeout;
  assign busy            = (state_q != IDLE);

  // Upper bits of the generic response struct are unused at narrower widths.
  logic rsp_unused;
  assign rsp_unused = ^{rsp_q.id, rsp_q.quotient, rsp_q.remainder};

endmodule

// File: tb/tb_divider_sched_rr.sv
// Self-checking bench for divider_sched_rr: behavioural divider with
// programmable latency plus a round-robin/arithmetic reference model.
module tb_divider_sched_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_dividend;
  logic [63:0] req_divisor;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_quotient;
  logic [15:0] rsp_remainder;
  logic        rsp_div_by_zero;
  logic        rsp_timeout;
  logic        div_start;
  logic [15:0] div_dividend;
  logic [15:0] div_divisor;
  logic [15:0] div_quotient;
  logic [15:0] div_remainder;
  wire         div_done;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  // Divider model state
  int          divLatency   = 1;
  logic        modelDone    = 1'b0;
  logic        spuriousDone = 1'b0;
  bit          pending      = 1'b0;
  int          pendCnt      = 0;
  logic [15:0] latA;
  logic [15:0] latB;

  // Reference scheduler state
  int          ptr_m = 0;
  logic [15:0] opA [4];
  logic [15:0] opB [4];
  int          lastGrant;
  logic [15:0] obsQ;
  logic [15:0] obsR;
  logic        obsTo;

  assign div_done = modelDone | spuriousDone;

  always #5 clk = ~clk;

  divider_sched_rr #(
    .NUM_REQ(4),
    .WIDTH  (16),
    .TIMEOUT(64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_quotient   (rsp_quotient),
    .rsp_remainder  (rsp_remainder),
    .rsp_div_by_zero(rsp_div_by_zero),
    .rsp_timeout    (rsp_timeout),
    .div_start      (div_start),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder),
    .div_done       (div_done),
    .busy           (busy)
  );

  // Behavioural divider: done pulses divLatency cycles after the start cycle;
  // divLatency of 0 models a hung core that never answers.
  always @(negedge clk) begin
    modelDone = 1'b0;
    if (pending) begin
      pendCnt = pendCnt - 1;
      if (pendCnt == 0) begin
        pending       = 1'b0;
        modelDone     = 1'b1;
        div_quotient  = latA / latB;
        div_remainder = latA % latB;
      end
    end
    if (div_start === 1'b1) begin
      latA = div_dividend;
      latB = div_divisor;
      if (divLatency > 0) begin
        pending = 1'b1;
        pendCnt = divLatency;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pickGrant(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (mask[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
    end
    return -1;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
    checkOutput({tag, "_rsp_q"}, 32'(rsp_quotient), 32'h0);
    checkOutput({tag, "_rsp_r"}, 32'(rsp_remainder), 32'h0);
    checkOutput({tag, "_flags"}, 32'({rsp_div_by_zero, rsp_timeout}), 32'h0);
    checkOutput({tag, "_div_start"}, 32'(div_start), 32'h0);
    checkOutput({tag, "_div_ops"}, {div_dividend, div_divisor}, 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Called at the negedge of an idle cycle; returns at the negedge of the
  // idle cycle following the response handshake.
  task automatic applyStimulus(input logic [3:0] mask, input int lat, input int hold);
    int          g;
    int          n;
    int          expN;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expQ;
    logic [15:0] expR;
    logic        expZ;
    logic        expT;
    divLatency = lat;
    req_valid  = mask;
    for (int i = 0; i < 4; i++) begin
      req_dividend[i*16 +: 16] = opA[i];
      req_divisor[i*16 +: 16]  = opB[i];
    end
    #1;
    g         = pickGrant(mask);
    lastGrant = g;
    checkOutput("grant", 32'(req_ready), 32'(4'b0001 << g));
    ptr_m = (g + 1) % 4;
    a     = opA[g];
    b     = opB[g];
    expZ  = (b == 16'd0);
    expT  = !expZ && (lat == 0);
    expQ  = expZ ? 16'hFFFF : (expT ? 16'h0 : a / b);
    expR  = expZ ? a        : (expT ? 16'h0 : a % b);
    expN  = expZ ? 0 : ((lat == 0) ? 65 : lat + 1);

    @(negedge clk);
    checkOutput("ready_pulse", 32'(req_ready), 32'h0);
    if (expZ) begin
      checkOutput("div0_no_start", 32'(div_start), 32'h0);
    end else begin
      checkOutput("div_start", 32'(div_start), 32'h1);
      checkOutput("div_operands", {div_dividend, div_divisor}, {a, b});
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rsp_latency", 32'(n), 32'(expN));
    checkOutput("rsp_id", 32'(rsp_id), 32'(g));
    checkOutput("rsp_qr", {rsp_quotient, rsp_remainder}, {expQ, expR});
    checkOutput("rsp_flags", 32'({rsp_div_by_zero, rsp_timeout}), 32'({expZ, expT}));
    obsQ  = rsp_quotient;
    obsR  = rsp_remainder;
    obsTo = rsp_timeout;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("bp_hold", {rsp_quotient, rsp_remainder}, {expQ, expR});
      checkOutput("bp_quiet", 32'({rsp_valid, req_ready, div_start, rsp_id}),
                  32'({1'b1, 4'b0000, 1'b0, 2'(g)}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("after_handshake", 32'({rsp_valid, busy}), 32'h0);
  endtask

  initial begin
    int expOrder [5];
    expOrder     = '{0, 1, 2, 3, 0};
    rst          = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b0;
    div_quotient = 16'hDEAD;
    div_remainder = 16'hBEEF;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] round-robin with all requesters valid");
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 4; i++) begin
        opA[i] = 16'($urandom);
        opB[i] = 16'($urandom_range(1, 300));
      end
      applyStimulus(4'hF, $urandom_range(1, 6), 0);
      checkOutput("rr_order", 32'(lastGrant), 32'(expOrder[t]));
    end

    $display("[TB] single request 1000/7");
    opA[1] = 16'd1000;
    opB[1] = 16'd7;
    applyStimulus(4'b0010, 5, 0);
    checkOutput("single_qr", {obsQ, obsR}, {16'd142, 16'd6});

    $display("[TB] divide by zero");
    opA[2] = 16'h1234;
    opB[2] = 16'h0000;
    applyStimulus(4'b0100, 5, 0);
    checkOutput("div0_qr", {obsQ, obsR}, {16'hFFFF, 16'h1234});

    $display("[TB] hung divider");
    opA[0] = 16'd500;
    opB[0] = 16'd3;
    applyStimulus(4'b0001, 0, 0);
    checkOutput("timeout_flag", 32'(obsTo), 32'h1);
    req_valid    = '0;
    spuriousDone = 1'b1;
    @(negedge clk);
    spuriousDone = 1'b0;
    checkOutput("spurious_done", 32'({rsp_valid, busy}), 32'h0);
    applyStimulus(4'b0001, 4, 0);

    $display("[TB] done near the watchdog limit");
    opA[3] = 16'd9999;
    opB[3] = 16'd10;
    applyStimulus(4'b1000, 63, 0);
    applyStimulus(4'b1000, 64, 0);

    $display("[TB] response backpressure");
    for (int i = 0; i < 4; i++) begin
      opA[i] = 16'($urandom);
      opB[i] = 16'($urandom_range(1, 65535));
    end
    applyStimulus(4'hF, 3, 10);

    $display("[TB] reset during WAIT");
    opA[3]     = 16'd777;
    opB[3]     = 16'd5;
    divLatency = 20;
    req_valid  = 4'b1000;
    req_dividend[48 +: 16] = opA[3];
    req_divisor[48 +: 16]  = opB[3];
    repeat (4) @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    checkResetOutputs("midrst");
    rst       = 1'b0;
    req_valid = '0;
    ptr_m     = 0;
    repeat (25) begin
      @(negedge clk);
      checkOutput("stray_done", 32'({rsp_valid, busy}), 32'h0);
    end
    applyStimulus(4'hF, 2, 0);
    checkOutput("ptr_after_rst", 32'(lastGrant), 32'h0);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        opA[i] = 16'($urandom);
        case ($urandom_range(0, 7))
          0:       opB[i] = 16'h0;
          1, 2:    opB[i] = 16'($urandom_range(1, 15));
          default: opB[i] = 16'($urandom_range(1, 65535));
        endcase
      end
      applyStimulus(4'($urandom_range(1, 15)),
                    ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 8),
                    $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
